// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and default constants for the two-port on-chip memory arbiter.
package onchip_mem_arb_pkg;

   localparam int DEF_ADDR_W  = 20;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_DEPTH   = 786432;
   localparam int DEF_MAX_RUN = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERVE0 = 2'd1,
      ST_SERVE1 = 2'd2
   } arb_state_t;

   typedef logic port_idx_t;

   function automatic arb_state_t serve_state(input port_idx_t p);
      return p ? ST_SERVE1 : ST_SERVE0;
   endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
// Two-requester grant logic: alternates under contention, bounding runs to MAX_RUN grants.
module rr_grant2 #(
   parameter int MAX_RUN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   output logic       o_gnt_valid,
   output logic       o_gnt_idx,
   output logic [1:0] o_state
);
   import onchip_mem_arb_pkg::*;

   localparam int RUN_W = $clog2(MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   port_idx_t        r_last;
   port_idx_t        w_last_nxt;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_nxt;
   logic             w_gnt_valid;
   port_idx_t        w_gnt_idx;
   logic             w_serving;
   port_idx_t        w_cur;

   always_comb begin
      w_gnt_valid = |i_req;
      w_gnt_idx   = r_last;
      w_serving   = (r_state != ST_IDLE);
      w_cur       = (r_state == ST_SERVE1);
      w_state_nxt = ST_IDLE;
      w_last_nxt  = r_last;
      w_run_nxt   = '0;

      case (i_req)
         2'b01:   w_gnt_idx = 1'b0;
         2'b10:   w_gnt_idx = 1'b1;
         2'b11: begin
            // Contention: fresh start favours the port not served last; a full run hands over.
            if (!w_serving)
               w_gnt_idx = ~r_last;
            else if (r_run == RUN_MAX)
               w_gnt_idx = ~w_cur;
            else
               w_gnt_idx = w_cur;
         end
         default: w_gnt_idx = r_last;
      endcase

      if (w_gnt_valid) begin
         w_state_nxt = serve_state(w_gnt_idx);
         w_last_nxt  = w_gnt_idx;
         if (w_serving && (w_cur == w_gnt_idx))
            w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
         else
            w_run_nxt = RUN_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_run   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_run   <= w_run_nxt;
      end
   end

   assign o_gnt_valid = w_gnt_valid;
   assign o_gnt_idx   = w_gnt_idx;
   assign o_state     = r_state;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates two Avalon-style requesters onto one single-port on-chip memory (read latency 1).
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MAX_RUN = DEF_MAX_RUN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   p0_address,
   input  logic [DATA_W/8-1:0] p0_byteenable,
   input  logic                p0_read,
   input  logic                p0_write,
   input  logic [DATA_W-1:0]   p0_writedata,
   output logic                p0_waitrequest,
   output logic [DATA_W-1:0]   p0_readdata,
   output logic                p0_readdatavalid,
   input  logic [ADDR_W-1:0]   p1_address,
   input  logic [DATA_W/8-1:0] p1_byteenable,
   input  logic                p1_read,
   input  logic                p1_write,
   input  logic [DATA_W-1:0]   p1_writedata,
   output logic                p1_waitrequest,
   output logic [DATA_W-1:0]   p1_readdata,
   output logic                p1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [1:0]          o_dbg_state
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] OOR_LIMIT = (ADDR_W+1)'(DEPTH);

   // Handshake: a port requests while read or write is high; the request is taken in the
   // cycle its waitrequest is low. Reads return readdatavalid exactly one cycle later.
   logic [1:0]        w_req;
   logic              w_gnt_raw;
   logic              w_gnt;
   logic              w_sel;
   logic [1:0]        w_state;
   logic [ADDR_W-1:0] w_addr;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;
   logic              w_rd;
   logic              w_wr;
   logic              w_oor;
   logic [DATA_W-1:0] w_ret_data;
   logic [1:0]        r_rd_valid;
   logic              r_rd_zero;

   assign w_req = {p1_read | p1_write, p0_read | p0_write};

   rr_grant2 #(.MAX_RUN(MAX_RUN)) u_grant (
      .clk         (clk),
      .reset       (reset),
      .i_req       (w_req),
      .o_gnt_valid (w_gnt_raw),
      .o_gnt_idx   (w_sel),
      .o_state     (w_state)
   );

   assign w_gnt = w_gnt_raw & ~reset;

   always_comb begin
      w_addr  = p0_address;
      w_be    = p0_byteenable;
      w_wdata = p0_writedata;
      w_wr    = p0_write;
      w_rd    = p0_read & ~p0_write;
      if (w_sel) begin
         w_addr  = p1_address;
         w_be    = p1_byteenable;
         w_wdata = p1_writedata;
         w_wr    = p1_write;
         w_rd    = p1_read & ~p1_write;
      end
   end

   // Beyond the implemented words nothing touches the RAM; reads come back as zero.
   assign w_oor = ({1'b0, w_addr} >= OOR_LIMIT);

   assign p0_waitrequest = reset | (w_req[0] & ~(w_gnt & ~w_sel));
   assign p1_waitrequest = reset | (w_req[1] & ~(w_gnt &  w_sel));

   assign mem_address    = w_addr;
   assign mem_byteenable = w_be;
   assign mem_writedata  = w_wdata;
   assign mem_chipselect = w_gnt & ~w_oor;
   assign mem_write      = w_gnt & w_wr & ~w_oor;
   assign mem_clken      = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_valid <= '0;
         r_rd_zero  <= 1'b0;
      end else begin
         r_rd_valid <= {w_gnt & w_rd & w_sel, w_gnt & w_rd & ~w_sel};
         r_rd_zero  <= w_oor;
      end
   end

   assign w_ret_data       = r_rd_zero ? '0 : mem_readdata;
   assign p0_readdatavalid = r_rd_valid[0];
   assign p1_readdatavalid = r_rd_valid[1];
   assign p0_readdata      = r_rd_valid[0] ? w_ret_data : '0;
   assign p1_readdata      = r_rd_valid[1] ? w_ret_data : '0;
   assign o_dbg_state      = w_state;

endmodule
